// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared encodings, widths and helpers for the hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int c_NUM_REGS        = 8;
    localparam int c_REG_AW          = 3;
    localparam int c_CNT_W           = 2;
    localparam int c_WB_DIST_DEFAULT = 2;

    localparam logic [1:0] c_ST_RUN     = 2'b00;
    localparam logic [1:0] c_ST_DRAIN   = 2'b01;
    localparam logic [1:0] c_ST_HALTED  = 2'b10;

    // Halt sits in ID/EX, EX/MEM, MEM/WB before the pipe is empty.
    localparam logic [1:0] c_DRAIN_START = 2'd3;

    typedef logic [c_CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic ifidFlush;
        logic stallCtrl;
        logic idexFlush;
        logic pipeEn;
        logic halted;
    } ctrl_t;

    function automatic sb_cnt_t sb_dec(input sb_cnt_t c);
        return (c == '0) ? '0 : sb_cnt_t'(c - 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_if
// Brief    : Decode-side hazard inputs and pipeline control outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_if;

    logic [2:0] rsAddr;
    logic [2:0] rtAddr;
    logic       rsUsed;
    logic       rtUsed;
    logic [2:0] WrR;
    logic       RegWrite;
    logic       halt_IFID;
    logic       Jump;
    logic       takeBranch_EXMEM;
    logic       memBusy;

    logic       pcEn;
    logic       ifidEn;
    logic       ifidFlush;
    logic       stallCtrl;
    logic       idexFlush;
    logic       pipeEn;
    logic       halted;

    modport master (
        output rsAddr, rtAddr, rsUsed, rtUsed, WrR, RegWrite,
               halt_IFID, Jump, takeBranch_EXMEM, memBusy,
        input  pcEn, ifidEn, ifidFlush, stallCtrl, idexFlush, pipeEn, halted
    );

    modport slave (
        input  rsAddr, rtAddr, rsUsed, rtUsed, WrR, RegWrite,
               halt_IFID, Jump, takeBranch_EXMEM, memBusy,
        output pcEn, ifidEn, ifidFlush, stallCtrl, idexFlush, pipeEn, halted
    );

endinterface
`default_nettype wire

// File: rtl/dff_en.sv
`default_nettype none
// ============================================================================
// Module   : dff_en
// Brief    : Enabled register with asynchronous active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
module dff_en #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_sb_cell.sv
`default_nettype none
// ============================================================================
// Module   : sb_cell
// Brief    : One scoreboard write-pending counter (set / squash / decrement).
// Revision : 1.0 - initial release
// ============================================================================
module sb_cell
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_DIST = c_WB_DIST_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_set,
    input  wire logic i_squash,
    output sb_cnt_t   o_cnt
);

    localparam sb_cnt_t c_DIST = sb_cnt_t'(WB_DIST);

    sb_cnt_t w_next;

    // A counter still at full distance belongs to the writer in ID/EX.
    always_comb begin
        w_next = sb_dec(o_cnt);
        if (i_set) begin
            w_next = c_DIST;
        end else if (i_squash && (o_cnt == c_DIST)) begin
            w_next = '0;
        end
    end

    dff_en #(
        .WIDTH (c_CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_en (i_en),
        .i_d  (w_next),
        .o_q  (o_cnt)
    );

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : RAW scoreboard stall, branch/jump flush, mem freeze, halt drain.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_DIST = c_WB_DIST_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    hazard_if.slave   hz
);

    logic [1:0] r_state;
    logic [1:0] r_dcnt;
    sb_cnt_t    w_cnt [c_NUM_REGS];
    logic       w_hazard;
    logic       w_issue;
    logic       w_squash_halt;
    logic       w_sb_squash;
    ctrl_t      w_ctrl;

    assign w_hazard = (hz.rsUsed && (w_cnt[hz.rsAddr] != '0)) ||
                      (hz.rtUsed && (w_cnt[hz.rtAddr] != '0));

    // Only a branch older than the halt (halt still in ID/EX) can cancel it.
    assign w_squash_halt = (r_state == c_ST_DRAIN) && hz.takeBranch_EXMEM &&
                           (r_dcnt == c_DRAIN_START);

    always_comb begin
        w_ctrl = '{pcEn: 1'b1, ifidEn: 1'b1, ifidFlush: 1'b0, stallCtrl: 1'b0,
                   idexFlush: 1'b0, pipeEn: 1'b1, halted: 1'b0};
        if (r_state == c_ST_HALTED) begin
            w_ctrl        = '0;
            w_ctrl.halted = 1'b1;
        end else if (hz.memBusy) begin
            w_ctrl = '0;
        end else if (hz.takeBranch_EXMEM &&
                     ((r_state == c_ST_RUN) || w_squash_halt)) begin
            w_ctrl.ifidFlush = 1'b1;
            w_ctrl.idexFlush = 1'b1;
        end else if ((r_state == c_ST_DRAIN) || w_hazard) begin
            w_ctrl.pcEn      = 1'b0;
            w_ctrl.ifidEn    = 1'b0;
            w_ctrl.stallCtrl = 1'b1;
        end else if (hz.Jump) begin
            w_ctrl.ifidFlush = 1'b1;
        end
    end

    assign w_issue = w_ctrl.pipeEn && !w_ctrl.stallCtrl &&
                     !hz.takeBranch_EXMEM && (r_state == c_ST_RUN);

    assign w_sb_squash = hz.takeBranch_EXMEM && w_ctrl.pipeEn;

    generate
        for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_sb
            sb_cell #(
                .WB_DIST (WB_DIST)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .i_en     (w_ctrl.pipeEn),
                .i_set    (w_issue && hz.RegWrite && (hz.WrR == 3'(gi))),
                .i_squash (w_sb_squash),
                .o_cnt    (w_cnt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_dcnt  <= 2'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_issue && hz.halt_IFID) begin
                        r_state <= c_ST_DRAIN;
                        r_dcnt  <= c_DRAIN_START;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_ctrl.pipeEn) begin
                        if (w_squash_halt) begin
                            r_state <= c_ST_RUN;
                            r_dcnt  <= 2'd0;
                        end else if (r_dcnt == 2'd1) begin
                            r_state <= c_ST_HALTED;
                            r_dcnt  <= 2'd0;
                        end else begin
                            r_dcnt <= r_dcnt - 2'd1;
                        end
                    end
                end
                c_ST_HALTED: begin
                    r_state <= c_ST_HALTED;
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_dcnt  <= 2'd0;
                end
            endcase
        end
    end

    assign hz.pcEn      = w_ctrl.pcEn;
    assign hz.ifidEn    = w_ctrl.ifidEn;
    assign hz.ifidFlush = w_ctrl.ifidFlush;
    assign hz.stallCtrl = w_ctrl.stallCtrl;
    assign hz.idexFlush = w_ctrl.idexFlush;
    assign hz.pipeEn    = w_ctrl.pipeEn;
    assign hz.halted    = w_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Output vector order: pcEn ifidEn ifidFlush stallCtrl idexFlush pipeEn halted
    localparam logic [6:0] c_E_RUN    = 7'b1100010;
    localparam logic [6:0] c_E_BRANCH = 7'b1110110;
    localparam logic [6:0] c_E_STALL  = 7'b0001010;
    localparam logic [6:0] c_E_JUMP   = 7'b1110010;
    localparam logic [6:0] c_E_BUSY   = 7'b0000000;
    localparam logic [6:0] c_E_HALTED = 7'b0000001;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_if hz();

    hazard_ctrl #(
        .WB_DIST (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {hz.pcEn, hz.ifidEn, hz.ifidFlush, hz.stallCtrl,
                hz.idexFlush, hz.pipeEn, hz.halted};
    endfunction

    task automatic clear_inputs();
        hz.rsAddr = 3'd0; hz.rtAddr = 3'd0; hz.rsUsed = 1'b0; hz.rtUsed = 1'b0;
        hz.WrR = 3'd0; hz.RegWrite = 1'b0; hz.halt_IFID = 1'b0; hz.Jump = 1'b0;
        hz.takeBranch_EXMEM = 1'b0; hz.memBusy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        hz.rsAddr = 3'd3; hz.rsUsed = 1'b1;
        #2;
        total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL reset_outputs: got %b want %b", outs(), c_E_RUN);
        end
        #10;
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_raw_stall();
        hz.RegWrite = 1'b1; hz.WrR = 3'd3;
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL raw_writer_issue: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
        hz.rsAddr = 3'd3; hz.rsUsed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2; total++;
            if (outs() !== c_E_STALL) begin
                bad++; $display("FAIL raw_stall c%0d: got %b want %b", i, outs(), c_E_STALL);
            end
            tick();
        end
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL raw_release: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_membusy_stretch();
        hz.RegWrite = 1'b1; hz.WrR = 3'd3;
        tick();
        clear_inputs();
        hz.rsAddr = 3'd3; hz.rsUsed = 1'b1;
        #2; total++;
        if (outs() !== c_E_STALL) begin
            bad++; $display("FAIL busy_stall_first: got %b want %b", outs(), c_E_STALL);
        end
        tick();
        hz.memBusy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2; total++;
            if (outs() !== c_E_BUSY) begin
                bad++; $display("FAIL busy_freeze c%0d: got %b want %b", i, outs(), c_E_BUSY);
            end
            tick();
        end
        hz.memBusy = 1'b0;
        #2; total++;
        if (outs() !== c_E_STALL) begin
            bad++; $display("FAIL busy_stall_held: got %b want %b", outs(), c_E_STALL);
        end
        tick();
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL busy_release: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rt_rewrite();
        hz.RegWrite = 1'b1; hz.WrR = 3'd4;
        tick();
        // second writer to the busy r4; rsAddr matches but is unused
        hz.rsAddr = 3'd4; hz.rsUsed = 1'b0;
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL rewrite_unused_src: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
        hz.rtAddr = 3'd4; hz.rtUsed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2; total++;
            if (outs() !== c_E_STALL) begin
                bad++; $display("FAIL rewrite_rt_stall c%0d: got %b want %b", i, outs(), c_E_STALL);
            end
            tick();
        end
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL rewrite_rt_release: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_jump();
        hz.Jump = 1'b1;
        #2; total++;
        if (outs() !== c_E_JUMP) begin
            bad++; $display("FAIL jump_flush: got %b want %b", outs(), c_E_JUMP);
        end
        tick();
        clear_inputs();
        hz.RegWrite = 1'b1; hz.WrR = 3'd6;
        tick();
        clear_inputs();
        hz.Jump = 1'b1; hz.rsAddr = 3'd6; hz.rsUsed = 1'b1;
        #2; total++;
        if (outs() !== c_E_STALL) begin
            bad++; $display("FAIL jump_hazard_stall: got %b want %b", outs(), c_E_STALL);
        end
        tick(); tick();
        #2; total++;
        if (outs() !== c_E_JUMP) begin
            bad++; $display("FAIL jump_after_stall: got %b want %b", outs(), c_E_JUMP);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_squash();
        hz.RegWrite = 1'b1; hz.WrR = 3'd5;
        tick();
        // squashed ID instr also claims r7 and reads r5
        hz.WrR = 3'd7; hz.rsAddr = 3'd5; hz.rsUsed = 1'b1; hz.takeBranch_EXMEM = 1'b1;
        #2; total++;
        if (outs() !== c_E_BRANCH) begin
            bad++; $display("FAIL branch_flush: got %b want %b", outs(), c_E_BRANCH);
        end
        tick();
        clear_inputs();
        hz.rsAddr = 3'd5; hz.rsUsed = 1'b1; hz.rtAddr = 3'd7; hz.rtUsed = 1'b1;
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL branch_cnt_cleared: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_halt_drain();
        hz.halt_IFID = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #2; total++;
            if (outs() !== c_E_STALL) begin
                bad++; $display("FAIL halt_drain c%0d: got %b want %b", i, outs(), c_E_STALL);
            end
            tick();
        end
        hz.Jump = 1'b1; hz.takeBranch_EXMEM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2; total++;
            if (outs() !== c_E_HALTED) begin
                bad++; $display("FAIL halt_sticky c%0d: got %b want %b", i, outs(), c_E_HALTED);
            end
            tick();
        end
        clear_inputs();
        pulse_reset();
    endtask

    task automatic test_halt_squash();
        hz.halt_IFID = 1'b1;
        tick();
        clear_inputs();
        hz.takeBranch_EXMEM = 1'b1;
        #2; total++;
        if (outs() !== c_E_BRANCH) begin
            bad++; $display("FAIL halt_squash_flush: got %b want %b", outs(), c_E_BRANCH);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            #2; total++;
            if (outs() !== c_E_RUN) begin
                bad++; $display("FAIL halt_squash_run c%0d: got %b want %b", i, outs(), c_E_RUN);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        hz.RegWrite = 1'b1; hz.WrR = 3'd2;
        tick();
        clear_inputs();
        hz.halt_IFID = 1'b1;
        #2; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL arst_halt_issue: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
        hz.rsAddr = 3'd2; hz.rsUsed = 1'b1;
        #2; total++;
        if (outs() !== c_E_STALL) begin
            bad++; $display("FAIL arst_in_drain: got %b want %b", outs(), c_E_STALL);
        end
        #1 rst = 1'b1;
        #1; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL arst_immediate: got %b want %b", outs(), c_E_RUN);
        end
        rst = 1'b0;
        #1; total++;
        if (outs() !== c_E_RUN) begin
            bad++; $display("FAIL arst_released: got %b want %b", outs(), c_E_RUN);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_raw_stall();
        test_membusy_stretch();
        test_rt_rewrite();
        test_jump();
        test_branch_squash();
        test_halt_drain();
        test_halt_squash();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
